// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM responder and its storage array.
package sram_pkg;

  localparam int WORD_W      = 16;
  localparam int DEF_DEPTH_W = 10;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DONE,
    WR_HOLD
  } state_t;

endpackage

// File: rtl/sram_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
// reset_n (synchronous, active-low) clears only the read register, never the contents.
module sram_array
  import sram_pkg::*;
#(
  parameter int DEPTH_W = DEF_DEPTH_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DEPTH_W-1:0] addr,
  input  word_t              wdata,
  input  logic [1:0]         be,
  input  logic               rd_en,
  output word_t              rdata
);

  word_t mem [2**DEPTH_W];

  always_ff @(posedge clk) begin
    if (be[1]) mem[addr][15:8] <= wdata[15:8];
    if (be[0]) mem[addr][7:0]  <= wdata[7:0];
  end

  // The read register only moves on a read, so it holds its value between reads.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_responder.sv
// On-chip SRAM substitute driven by the SLC-3 active-low memory strobes.
// Define MEM_BYTE_LANE_EN to honour Mem_UB/Mem_LB; otherwise every access is a full word.
module sram_responder
  import sram_pkg::*;
#(
  parameter int DEPTH_W   = DEF_DEPTH_W,
  parameter int READ_WAIT = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_CE,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic        Mem_UB,
  input  logic        Mem_LB,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_in,
  output logic [15:0] Data_out,
  output logic        Data_valid,
  output logic        Busy,
  output logic        Err
);

  state_t state, state_next;
  logic [2:0]  count, count_next;
  word_t       addr_q, addr_next;
  logic [1:0]  lanes_q, lanes_next;
  logic        err_q, err_next;
  word_t       mask_q;
  logic        wr_en, rd_en;
  word_t       rd_addr;
  logic [1:0]  rd_lanes;
  logic        rd_oor;
  logic [1:0]  lanes_live;
  logic        oor_live;
  logic [1:0]  wr_be;
  word_t       rdata;

`ifdef MEM_BYTE_LANE_EN
  assign lanes_live = {~Mem_UB, ~Mem_LB};
`else
  logic unused_lanes;
  assign unused_lanes = Mem_UB ^ Mem_LB;
  assign lanes_live   = 2'b11;
`endif

  assign oor_live = (ADDR >> DEPTH_W) != 16'h0000;

  always_comb begin
    state_next = state;
    count_next = count;
    addr_next  = addr_q;
    lanes_next = lanes_q;
    err_next   = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = addr_q;
    rd_lanes   = lanes_q;
    rd_oor     = (addr_q >> DEPTH_W) != 16'h0000;
    case (state)
      IDLE: begin
        if (!Mem_CE) begin
          if (!Mem_WE) begin
            state_next = WR_HOLD;
            wr_en      = !oor_live && (lanes_live != 2'b00);
            err_next   = !Mem_OE || oor_live || (lanes_live == 2'b00);
          end else if (!Mem_OE) begin
            addr_next  = ADDR;
            lanes_next = lanes_live;
            count_next = 3'(READ_WAIT);
            err_next   = oor_live;
            if (READ_WAIT == 0) begin
              // Zero-wait reads issue straight from the live bus values.
              state_next = RD_DONE;
              rd_en      = 1'b1;
              rd_addr    = ADDR;
              rd_lanes   = lanes_live;
              rd_oor     = oor_live;
            end else begin
              state_next = RD_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        if (Mem_CE || Mem_OE) begin
          state_next = IDLE;
        end else begin
          count_next = count - 3'd1;
          if (count == 3'd1) begin
            state_next = RD_DONE;
            rd_en      = 1'b1;
          end
        end
      end
      RD_DONE: begin
        if (Mem_CE || Mem_OE) state_next = IDLE;
      end
      WR_HOLD: begin
        if (Mem_WE || Mem_CE) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_be = (wr_en && Reset) ? lanes_live : 2'b00;

  // The read mask is captured with the read so Data_out stays stable afterwards.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      count   <= 3'd0;
      addr_q  <= '0;
      lanes_q <= 2'b00;
      err_q   <= 1'b0;
      mask_q  <= '0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      addr_q  <= addr_next;
      lanes_q <= lanes_next;
      err_q   <= err_next;
      if (rd_en) begin
        mask_q <= rd_oor ? 16'h0000 : {{8{rd_lanes[1]}}, {8{rd_lanes[0]}}};
      end
    end
  end

  sram_array #(
    .DEPTH_W(DEPTH_W)
  ) u_array (
    .clk    (Clk),
    .reset_n(Reset),
    .addr   (rd_en ? rd_addr[DEPTH_W-1:0] : ADDR[DEPTH_W-1:0]),
    .wdata  (Data_in),
    .be     (wr_be),
    .rd_en  (rd_en && Reset),
    .rdata  (rdata)
  );

  assign Data_out   = rdata & mask_q;
  assign Data_valid = (state == RD_DONE);
  assign Busy       = (state == RD_WAIT) || (state == WR_HOLD);
  assign Err        = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench: two responders (READ_WAIT 0 and 3) share one strobe bus and are
// compared every cycle against a transaction-level model plus directed literal checks.
module tb_sram_responder;

  logic        Clk = 1'b0;
  logic        Reset, Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;
  logic [15:0] ADDR, Data_in;
  logic [15:0] dout0, dout3;
  logic        valid0, valid3, busy0, busy3, err0, err3;
  int          checks = 0;
  int          errors = 0;

  always #5 Clk = ~Clk;

  sram_responder #(.DEPTH_W(10), .READ_WAIT(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .ADDR(ADDR), .Data_in(Data_in),
    .Data_out(dout0), .Data_valid(valid0), .Busy(busy0), .Err(err0)
  );

  sram_responder #(.DEPTH_W(10), .READ_WAIT(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .ADDR(ADDR), .Data_in(Data_in),
    .Data_out(dout3), .Data_valid(valid3), .Busy(busy3), .Err(err3)
  );

  // Model: a read is pending with a number of cycles left until data appears.
  logic [15:0] mmem [2][1024];
  bit          live [2];
  bit          reading [2];
  int          left [2];
  bit          held [2];
  logic [15:0] raddr [2];
  logic [1:0]  rlanes [2];
  logic [15:0] xout [2];
  bit          xerr [2];

  function automatic logic [15:0] modelRead(int k, logic [15:0] a, logic [1:0] ln);
    if (a >= 16'd1024) return 16'h0000;
    return mmem[k][a[9:0]] & {{8{ln[1]}}, {8{ln[0]}}};
  endfunction

  always @(posedge Clk) begin
    logic [1:0] ln;
`ifdef MEM_BYTE_LANE_EN
    ln = {~Mem_UB, ~Mem_LB};
`else
    ln = 2'b11;
`endif
    for (int k = 0; k < 2; k++) begin
      xerr[k] = 1'b0;
      if (!Reset) begin
        live[k] = 1'b1; reading[k] = 1'b0; held[k] = 1'b0; xout[k] = 16'h0000;
      end else if (held[k]) begin
        if (Mem_WE || Mem_CE) held[k] = 1'b0;
      end else if (reading[k]) begin
        if (Mem_CE || Mem_OE) reading[k] = 1'b0;
        else if (left[k] > 0) begin
          left[k] = left[k] - 1;
          if (left[k] == 0) xout[k] = modelRead(k, raddr[k], rlanes[k]);
        end
      end else if (!Mem_CE) begin
        if (!Mem_WE) begin
          held[k] = 1'b1;
          if (ADDR < 16'd1024) begin
            if (ln[1]) mmem[k][ADDR[9:0]][15:8] = Data_in[15:8];
            if (ln[0]) mmem[k][ADDR[9:0]][7:0]  = Data_in[7:0];
          end
          xerr[k] = !Mem_OE || (ADDR >= 16'd1024) || (ln == 2'b00);
        end else if (!Mem_OE) begin
          reading[k] = 1'b1;
          left[k]    = (k == 1) ? 3 : 0;
          raddr[k]   = ADDR;
          rlanes[k]  = ln;
          xerr[k]    = ADDR >= 16'd1024;
          if (left[k] == 0) xout[k] = modelRead(k, ADDR, ln);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of both DUTs against the model, on the falling edge.
  always @(negedge Clk) begin
    for (int k = 0; k < 2; k++) begin
      if (live[k]) begin
        checkOutput(k ? "m3_out" : "m0_out", k ? dout3 : dout0, xout[k]);
        checkOutput(k ? "m3_valid" : "m0_valid", {15'd0, k ? valid3 : valid0},
                    {15'd0, reading[k] && left[k] == 0});
        checkOutput(k ? "m3_busy" : "m0_busy", {15'd0, k ? busy3 : busy0},
                    {15'd0, held[k] || (reading[k] && left[k] > 0)});
        checkOutput(k ? "m3_err" : "m0_err", {15'd0, k ? err3 : err0}, {15'd0, xerr[k]});
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic ce, input logic oe, input logic we,
                               input logic [15:0] a, input logic [15:0] d);
    Reset = rst; Mem_CE = ce; Mem_OE = oe; Mem_WE = we; ADDR = a; Data_in = d;
    @(posedge Clk);
    #2;
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [15:0] a);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, a, 16'h0000);
  endtask

  initial begin
    Mem_UB = 1'b0; Mem_LB = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
    checkOutput("rst_out0", dout0, 16'h0000);
    checkOutput("rst_out3", dout3, 16'h0000);
    checkOutput("rst_valid3", {15'd0, valid3}, 16'h0000);
    checkOutput("rst_busy3", {15'd0, busy3}, 16'h0000);

    // Write then read: RW0 valid one cycle after OE, RW3 four cycles after.
    wr(16'h0003, 16'hBEEF);
    checkOutput("wr_busy0", {15'd0, busy0}, 16'h0001);
    idle();
    rd(16'h0003);
    checkOutput("rd0_valid", {15'd0, valid0}, 16'h0001);
    checkOutput("rd0_data", dout0, 16'hBEEF);
    checkOutput("rd3_notyet", {15'd0, valid3}, 16'h0000);
    rd(16'h0000);
    rd(16'h0000);
    checkOutput("rd3_busy", {15'd0, busy3}, 16'h0001);
    rd(16'h0000);
    checkOutput("rd3_valid", {15'd0, valid3}, 16'h0001);
    checkOutput("rd3_data", dout3, 16'hBEEF);
    idle();
    checkOutput("rd3_drop", {15'd0, valid3}, 16'h0000);
    checkOutput("rd3_keep", dout3, 16'hBEEF);

    // Aborted wait-state read never raises Data_valid.
    wr(16'h0005, 16'h1234);
    idle();
    rd(16'h0005);
    rd(16'h0005);
    idle();
    checkOutput("abort_valid3", {15'd0, valid3}, 16'h0000);
    checkOutput("abort_busy3", {15'd0, busy3}, 16'h0000);
    for (int i = 0; i < 4; i++) rd(16'h0005);
    checkOutput("rd5_data3", dout3, 16'h1234);
    idle();

    // Long write hold commits only the first data word.
    for (int i = 1; i <= 5; i++) wr(16'h0010, 16'(i));
    idle();
    checkOutput("model_mem16", mmem[0][16], 16'h0001);
    for (int i = 0; i < 4; i++) rd(16'h0010);
    checkOutput("hold_data0", dout0, 16'h0001);
    checkOutput("hold_data3", dout3, 16'h0001);
    idle();

    // Out-of-range read.
    rd(16'h0400);
    checkOutput("oor_err0", {15'd0, err0}, 16'h0001);
    checkOutput("oor_err3", {15'd0, err3}, 16'h0001);
    rd(16'h0400);
    checkOutput("oor_errpulse", {15'd0, err3}, 16'h0000);
    rd(16'h0400);
    rd(16'h0400);
    checkOutput("oor_valid3", {15'd0, valid3}, 16'h0001);
    checkOutput("oor_data3", dout3, 16'h0000);
    idle();

    // OE and WE together: write wins, Err pulses, no read.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h00AA);
    checkOutput("both_err", {15'd0, err3}, 16'h0001);
    checkOutput("both_valid0", {15'd0, valid0}, 16'h0000);
    checkOutput("both_busy0", {15'd0, busy0}, 16'h0001);
    idle();
    for (int i = 0; i < 4; i++) rd(16'h0002);
    checkOutput("both_data3", dout3, 16'h00AA);
    idle();

    // Reset in the middle of a wait-state read; memory survives.
    rd(16'h0003);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 16'h0000);
    checkOutput("mrst_busy3", {15'd0, busy3}, 16'h0000);
    checkOutput("mrst_valid3", {15'd0, valid3}, 16'h0000);
    checkOutput("mrst_out3", dout3, 16'h0000);
    idle();
    for (int i = 0; i < 4; i++) rd(16'h0003);
    checkOutput("mrst_keep3", dout3, 16'hBEEF);
    idle();

    // Byte lanes.
    wr(16'h0007, 16'hFFFF);
    idle();
    Mem_LB = 1'b1;
    wr(16'h0007, 16'h1200);
    Mem_LB = 1'b0;
    idle();
    Mem_UB = 1'b1;
    for (int i = 0; i < 4; i++) rd(16'h0007);
    Mem_UB = 1'b0;
`ifdef MEM_BYTE_LANE_EN
    checkOutput("lane_rd3", dout3, 16'h00FF);
`else
    checkOutput("lane_rd3", dout3, 16'h1200);
`endif
    idle();
    Mem_UB = 1'b1; Mem_LB = 1'b1;
    wr(16'h0007, 16'h0000);
`ifdef MEM_BYTE_LANE_EN
    checkOutput("nolane_err", {15'd0, err3}, 16'h0001);
`else
    checkOutput("nolane_err", {15'd0, err3}, 16'h0000);
`endif
    Mem_UB = 1'b0; Mem_LB = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) rd(16'h0007);
`ifdef MEM_BYTE_LANE_EN
    checkOutput("lane_full3", dout3, 16'h12FF);
`else
    checkOutput("lane_full3", dout3, 16'h0000);
`endif
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the SLC-3 control unit's active-low SRAM strobes: Mem_CE, Mem_OE, Mem_WE, Mem_UB and Mem_LB.
- Services reads and writes addressed by MAR.
- Returns read data to the MDR path with a fixed, parameterised latency. With the default latency, MDR loads on the second cycle of OE assertion.
- Acts as the on-chip substitute for external SRAM in simulation and FPGA builds.

Parameters:
- DEPTH_W, 10, log2 of word count. The array holds 1024 x 16-bit words.
- READ_WAIT, 0, extra wait cycles inserted before read data is valid. Range 0..7.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset (asserted when 0).
- Mem_CE  in  1  chip enable, active-low.
- Mem_OE  in  1  output enable / read request, active-low.
- Mem_WE  in  1  write enable, active-low.
- Mem_UB  in  1  upper byte lane select, active-low.
- Mem_LB  in  1  lower byte lane select, active-low.
- ADDR  in  16  word address from MAR.
- Data_in  in  16  write data from MDR.
- Data_out  out  16  read data to MDR mux.
- Data_valid  out  1  Data_out holds valid read data this cycle.
- Busy  out  1  read wait or write hold in progress.
- Err  out  1  one-cycle pulse on a protocol or address error.

Behaviour:
- Reset (Reset=0 at an edge):
  - State goes to IDLE.
  - Data_out=16'h0000, Data_valid=0, Busy=0, Err=0, wait counter=0.
  - Memory contents are retained.
  - Reset overrides any operation in progress; a pending read or write hold is dropped.
- Range check: an address is out of range when ADDR[15:DEPTH_W] != 0.
- Error pulse: Err asserts for exactly the cycle after the offending request is sampled.
- IDLE:
  - CE=0, WE=0: commit the write at this edge to mem[ADDR[DEPTH_W-1:0]], then go to WR_HOLD. This applies regardless of OE.
  - CE=0, WE=0, OE=0 (both strobes low): the write wins, no read is started, and Err pulses.
  - CE=0, OE=0, WE=1: latch ADDR into addr_q and load counter=READ_WAIT. Go to RD_DONE if READ_WAIT=0, else to RD_WAIT.
  - CE=1: stay in IDLE and ignore all other strobes.
- WR_HOLD:
  - Busy=1; no further writes occur.
  - Return to IDLE once WE=1 or CE=1 is sampled.
  - Exactly one write per WE assertion, however long WE is held.
- RD_WAIT:
  - Busy=1; counter decrements each cycle.
  - OE=1 or CE=1 aborts to IDLE; Data_valid is never raised.
  - When counter==1 at an edge, go to RD_DONE.
- RD_DONE:
  - Data_out=mem[addr_q], registered; Data_valid=1; Busy=0.
  - Hold while CE=0 and OE=0.
  - On OE=1 or CE=1, go to IDLE; Data_valid drops the next cycle.
  - Data_out keeps its last value after Data_valid drops.
- Latency: with READ_WAIT=N, OE is sampled low at edge t and Data_valid is high in cycle t+1+N.
  - With N=0, the CPU's two-cycle read (OE in cycle t, MDR loads at end of cycle t+1) captures valid data.
- ADDR changes during a read are ignored; addr_q is used.
- Out-of-range read: completes with normal timing, Data_out=16'h0000, Err pulses.
- Out-of-range write: dropped, Err pulses, still enters WR_HOLD.

Optional Feature:
- Macro: MEM_BYTE_LANE_EN.
- Defined:
  - Writes update only lanes whose select is low: UB controls [15:8], LB controls [7:0].
  - Reads drive unselected lanes as 8'h00.
  - UB=LB=1 on a write stores nothing, enters WR_HOLD, and Err pulses.
- Undefined: Mem_UB and Mem_LB are ignored; every access is a full 16-bit word.

Decomposition:
- Package sram_pkg holds:
  - typedef word_t (logic [15:0]).
  - The state enum {IDLE, RD_WAIT, RD_DONE, WR_HOLD}.
  - Constants WORD_W=16 and DEF_DEPTH_W=10.
- One sub-module, sram_array: single-port synchronous RAM with a 2-bit byte-write enable and a registered read port. The FSM, counter, range check and error logic stay in sram_responder.

Test Plan:
- Write then read, READ_WAIT=0: CE=0, WE=0, ADDR=16'h0003, Data_in=16'hBEEF for one cycle, then CE=0, OE=0, ADDR=16'h0003 -> Data_valid=1 with Data_out=16'hBEEF exactly one cycle after OE is first sampled low.
- Wait states, READ_WAIT=3, mem[5]=16'h1234: hold OE=0 -> Busy=1 for 3 cycles, then Data_valid=1 with Data_out=16'h1234 in cycle t+4. Deassert OE at cycle t+2 on a repeat -> Data_valid stays 0 and state returns to IDLE.
- Long WE hold: WE=0 for 5 cycles at ADDR=16'h0010, with Data_in changing 16'h0001 to 16'h0005 across the hold -> mem[16]=16'h0001, exactly one write.
- Errors: read at ADDR=16'h0400 -> Data_out=16'h0000 and one Err pulse. OE=0 and WE=0 together at ADDR=16'h0002, Data_in=16'h00AA -> mem[2]=16'h00AA, one Err pulse, no Data_valid.
- Reset mid-read, READ_WAIT=3: assert Reset=0 during RD_WAIT -> next cycle Busy=0, Data_valid=0, Data_out=16'h0000, and previously written mem[3]=16'hBEEF is still readable.
- MEM_BYTE_LANE_EN defined, mem[7]=16'hFFFF: write 16'h1200 with UB=0, LB=1 -> mem[7]=16'h12FF. Read with LB=0, UB=1 -> Data_out=16'h00FF.
